// File: rtl/commit_exception_unit_pkg.sv
// Shared types and constants for the commit exception unit.
// Synchroniser depth is selected by EXT_INT_SYNC_EN (see commit_exception_unit_int_sync).
package commit_exception_unit_pkg;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

  localparam logic [4:0] CODE_INT  = 5'd0;
  localparam logic [4:0] CODE_ADEL = 5'd4;
  localparam logic [4:0] CODE_ADES = 5'd5;
  localparam logic [4:0] CODE_SYS  = 5'd8;
  localparam logic [4:0] CODE_BP   = 5'd9;
  localparam logic [4:0] CODE_RI   = 5'd10;
  localparam logic [4:0] CODE_OV   = 5'd12;

  typedef struct packed {
    logic adel_if;
    logic ri;
    logic ov;
    logic syscall;
    logic break_;
    logic adel_mem;
    logic ades_mem;
  } exc_flags_t;

  typedef struct packed {
    logic [7:0] im;
    logic       erl;
    logic       exl;
    logic       ie;
  } cp0_status_t;

  typedef struct packed {
    logic [1:0] ip_sw;
  } cp0_cause_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  code;
    logic [31:0] pc;
    logic        in_delay_slot;
    logic [31:0] badvaddr;
  } exception_t;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_EXC_REDIR  = 2'd1,
    ST_ERET_REDIR = 2'd2
  } redir_state_t;

  // Priority within one slot, highest first.
  function automatic logic [4:0] exc_code(input logic irq, input exc_flags_t f);
    if (irq)             return CODE_INT;
    else if (f.adel_if)  return CODE_ADEL;
    else if (f.ri)       return CODE_RI;
    else if (f.ov)       return CODE_OV;
    else if (f.syscall)  return CODE_SYS;
    else if (f.break_)   return CODE_BP;
    else if (f.adel_mem) return CODE_ADEL;
    else if (f.ades_mem) return CODE_ADES;
    else                 return CODE_INT;
  endfunction

endpackage

// File: rtl/commit_exception_unit_int_sync.sv
// Per-bit capture of the asynchronous hardware interrupt lines.
// EXT_INT_SYNC_EN selects a two-flop synchroniser; otherwise a single capture flop.
module commit_exception_unit_int_sync #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

`ifdef EXT_INT_SYNC_EN
  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end
`else
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sync <= '0;
    else       r_sync <= i_async;
  end
`endif

  assign o_sync = r_sync;

endmodule

// File: rtl/commit_exception_unit.sv
// Commit-stage exception/interrupt arbitration, cp0 exception record and fetch redirect.
// Interrupt synchroniser depth selected by EXT_INT_SYNC_EN.
//
// state         | meaning
// ST_IDLE       | commit flowing; exception/ERET decided combinationally
// ST_EXC_REDIR  | holding redirect to EXC_VECTOR until fetch accepts
// ST_ERET_REDIR | holding redirect to captured EPC until fetch accepts
module commit_exception_unit
  import commit_exception_unit_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
  parameter int          N_EXT_INT  = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           i_slot_valid,
  input  logic [1:0][31:0]     i_slot_pc,
  input  logic [1:0]           i_slot_in_delay_slot,
  input  exc_flags_t [1:0]     i_slot_exc,
  input  logic [1:0][31:0]     i_slot_mem_addr,
  input  logic [1:0]           i_slot_eret,
  input  logic [N_EXT_INT-1:0] i_ext_int,
  input  logic                 i_timer_interrupt,
  input  cp0_status_t          i_cp0_status,
  input  cp0_cause_t           i_cp0_cause,
  input  logic [31:0]          i_cp0_epc,
  output exception_t           o_exception,
  output logic                 o_is_eret,
  output logic [N_EXT_INT-1:0] o_cause_ip_hw,
  output logic [1:0]           o_commit_kill,
  output logic                 o_stall_commit,
  output logic                 o_redirect_valid,
  output logic [31:0]          o_redirect_pc,
  input  logic                 i_redirect_ready
);

  redir_state_t r_state;
  redir_state_t w_state_next;
  logic         r_eret_first;
  logic [31:0]  r_epc_hold;

  logic [N_EXT_INT-1:0] w_ip_sync;
  logic [5:0]           w_ip_hw;
  logic [7:0]           w_ip;
  logic                 w_int_pending;
  logic [1:0]           w_irq_slot;
  logic [1:0]           w_has_exc;
  logic [1:0][4:0]      w_code;
  logic [1:0][31:0]     w_badv;

  logic       w_take_exc;
  logic       w_take_eret;
  logic       w_sel;
  logic [1:0] w_kill_idle;
  exception_t w_exc_rec;

  commit_exception_unit_int_sync #(.WIDTH(N_EXT_INT)) u_int_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (i_ext_int),
    .o_sync  (w_ip_sync)
  );

  assign o_cause_ip_hw = w_ip_sync;
  assign w_ip_hw       = 6'(w_ip_sync);
  assign w_ip          = {w_ip_hw[5] | i_timer_interrupt, w_ip_hw[4:0], i_cp0_cause.ip_sw};
  assign w_int_pending = (|(w_ip & i_cp0_status.im)) & i_cp0_status.ie
                         & ~i_cp0_status.exl & ~i_cp0_status.erl;

  // Interrupt attaches to the oldest valid slot only.
  assign w_irq_slot = {w_int_pending & i_slot_valid[1],
                       w_int_pending & i_slot_valid[0] & ~i_slot_valid[1]};

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      w_code[s]    = exc_code(w_irq_slot[s], i_slot_exc[s]);
      w_has_exc[s] = i_slot_valid[s] & (w_irq_slot[s] | (|i_slot_exc[s]));
      if (w_irq_slot[s])
        w_badv[s] = '0;
      else if (i_slot_exc[s].adel_if)
        w_badv[s] = i_slot_pc[s];
      else if (w_code[s] == CODE_ADEL || w_code[s] == CODE_ADES)
        w_badv[s] = i_slot_mem_addr[s];
      else
        w_badv[s] = '0;
    end
  end

  // Age-ordered walk: the first exception or ERET found decides the bundle.
  always_comb begin
    w_take_exc  = 1'b0;
    w_take_eret = 1'b0;
    w_sel       = 1'b0;
    w_kill_idle = 2'b00;
    if (w_has_exc[1]) begin
      w_take_exc  = 1'b1;
      w_sel       = 1'b1;
      w_kill_idle = 2'b11;
    end else if (i_slot_valid[1] && i_slot_eret[1]) begin
      w_take_eret = 1'b1;
      w_kill_idle = 2'b01;
    end else if (w_has_exc[0]) begin
      w_take_exc  = 1'b1;
      w_kill_idle = 2'b01;
    end else if (i_slot_valid[0] && i_slot_eret[0]) begin
      w_take_eret = 1'b1;
    end
  end

  always_comb begin
    w_exc_rec               = '0;
    w_exc_rec.valid         = 1'b1;
    w_exc_rec.code          = w_code[w_sel];
    w_exc_rec.pc            = i_slot_pc[w_sel];
    w_exc_rec.in_delay_slot = i_slot_in_delay_slot[w_sel];
    w_exc_rec.badvaddr      = w_badv[w_sel];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_eret_first <= 1'b0;
      r_epc_hold   <= '0;
    end else begin
      r_state      <= w_state_next;
      r_eret_first <= (r_state == ST_IDLE) && (w_state_next == ST_ERET_REDIR);
      if (r_eret_first) r_epc_hold <= i_cp0_epc;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    o_exception      = '0;
    o_is_eret        = 1'b0;
    o_commit_kill    = 2'b00;
    o_stall_commit   = 1'b0;
    o_redirect_valid = 1'b0;
    o_redirect_pc    = '0;
    case (r_state)
      ST_IDLE: begin
        o_commit_kill = w_kill_idle;
        if (w_take_exc) begin
          o_exception  = w_exc_rec;
          w_state_next = ST_EXC_REDIR;
        end else if (w_take_eret) begin
          o_is_eret    = 1'b1;
          w_state_next = ST_ERET_REDIR;
        end
      end
      ST_EXC_REDIR: begin
        o_commit_kill    = 2'b11;
        o_stall_commit   = 1'b1;
        o_redirect_valid = 1'b1;
        o_redirect_pc    = EXC_VECTOR;
        if (i_redirect_ready) w_state_next = ST_IDLE;
      end
      ST_ERET_REDIR: begin
        o_commit_kill    = 2'b11;
        o_stall_commit   = 1'b1;
        o_redirect_valid = 1'b1;
        // First cycle sees the post-ERET cp0 EPC; later cycles replay the held copy.
        o_redirect_pc    = r_eret_first ? i_cp0_epc : r_epc_hold;
        if (i_redirect_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_commit_exception_unit.sv
// Scoreboard bench for commit_exception_unit: stimulus pushes expected events, a negedge monitor pops them.
module tb_commit_exception_unit;
  import commit_exception_unit_pkg::*;

  localparam logic [31:0] VEC = 32'hBFC0_0380;
`ifdef EXT_INT_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 1;
`endif
  localparam int K_EXC   = 0;
  localparam int K_ERET  = 1;
  localparam int K_REDIR = 2;

  typedef struct {
    int          kind;
    logic [4:0]  code;
    logic [31:0] pc;
    logic        dly;
    logic [31:0] badv;
    logic [1:0]  kill;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  logic             clk;
  logic             reset;
  logic [1:0]       slot_valid;
  logic [1:0][31:0] slot_pc;
  logic [1:0]       slot_dly;
  exc_flags_t [1:0] slot_exc;
  logic [1:0][31:0] slot_mem;
  logic [1:0]       slot_eret;
  logic [5:0]       ext_int;
  logic             timer_int;
  cp0_status_t      status;
  cp0_cause_t       cause;
  logic [31:0]      epc;
  exception_t       exc;
  logic             is_eret;
  logic [5:0]       cause_ip_hw;
  logic [1:0]       commit_kill;
  logic             stall_commit;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             redirect_ready;

  commit_exception_unit #(.EXC_VECTOR(VEC), .N_EXT_INT(6)) dut (
    .clk                  (clk),
    .reset                (reset),
    .i_slot_valid         (slot_valid),
    .i_slot_pc            (slot_pc),
    .i_slot_in_delay_slot (slot_dly),
    .i_slot_exc           (slot_exc),
    .i_slot_mem_addr      (slot_mem),
    .i_slot_eret          (slot_eret),
    .i_ext_int            (ext_int),
    .i_timer_interrupt    (timer_int),
    .i_cp0_status         (status),
    .i_cp0_cause          (cause),
    .i_cp0_epc            (epc),
    .o_exception          (exc),
    .o_is_eret            (is_eret),
    .o_cause_ip_hw        (cause_ip_hw),
    .o_commit_kill        (commit_kill),
    .o_stall_commit       (stall_commit),
    .o_redirect_valid     (redirect_valid),
    .o_redirect_pc        (redirect_pc),
    .i_redirect_ready     (redirect_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic exp_exc(input logic [4:0] code, input logic [31:0] pc, input logic dly,
                         input logic [31:0] badv, input logic [1:0] kill);
    exp_t e;
    e.kind = K_EXC; e.code = code; e.pc = pc; e.dly = dly; e.badv = badv; e.kill = kill;
    q.push_back(e);
  endtask

  task automatic exp_eret(input logic [1:0] kill);
    exp_t e;
    e.kind = K_ERET; e.code = '0; e.pc = '0; e.dly = 1'b0; e.badv = '0; e.kill = kill;
    q.push_back(e);
  endtask

  task automatic exp_redir(input logic [31:0] pc);
    exp_t e;
    e.kind = K_REDIR; e.code = '0; e.pc = pc; e.dly = 1'b0; e.badv = '0; e.kill = 2'b11;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_slots();
    slot_valid = '0;
    slot_pc    = '0;
    slot_dly   = '0;
    slot_exc   = '0;
    slot_mem   = '0;
    slot_eret  = '0;
  endtask

  // Bundle presented for one cycle, then redirect accepted on the next.
  task automatic finish_redirect();
    tick();
    clr_slots();
    tick();
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic ok;
    if (exc.valid || is_eret) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_commit_event: valid=%0b code=%0d pc=%h is_eret=%0b, nothing expected",
                 exc.valid, exc.code, exc.pc, is_eret);
      end else begin
        e = q.pop_front();
        if (e.kind == K_EXC)
          ok = exc.valid && !is_eret && exc.code == e.code && exc.pc == e.pc &&
               exc.in_delay_slot == e.dly && exc.badvaddr == e.badv && commit_kill == e.kill;
        else if (e.kind == K_ERET)
          ok = !exc.valid && is_eret && commit_kill == e.kill;
        else
          ok = 1'b0;
        if (!ok) begin
          errors++;
          $display("FAIL commit_event: got valid=%0b code=%0d pc=%h dly=%0b badv=%h eret=%0b kill=%b; want kind=%0d code=%0d pc=%h dly=%0b badv=%h kill=%b",
                   exc.valid, exc.code, exc.pc, exc.in_delay_slot, exc.badvaddr, is_eret, commit_kill,
                   e.kind, e.code, e.pc, e.dly, e.badv, e.kill);
        end
      end
    end
    if (redirect_valid) begin
      checks++;
      if (!stall_commit || commit_kill != 2'b11) begin
        errors++;
        $display("FAIL redirect_hold: got stall=%0b kill=%b want stall=1 kill=11", stall_commit, commit_kill);
      end
    end
    if (redirect_valid && redirect_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_redirect: pc=%h, nothing expected", redirect_pc);
      end else begin
        e = q.pop_front();
        if (e.kind != K_REDIR || redirect_pc != e.pc) begin
          errors++;
          $display("FAIL redirect: got pc=%h want kind=%0d pc=%h", redirect_pc, e.kind, e.pc);
        end
      end
    end
  end

  initial begin
    clk = 1'b0; reset = 1'b1; clr_slots();
    ext_int = '0; timer_int = 1'b0; status = '0; cause = '0; epc = '0; redirect_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_exc_valid", 32'(exc.valid), 0);
    chk("rst_exc_pc", exc.pc, 0);
    chk("rst_is_eret", 32'(is_eret), 0);
    chk("rst_kill", 32'(commit_kill), 0);
    chk("rst_stall", 32'(stall_commit), 0);
    chk("rst_redirect_valid", 32'(redirect_valid), 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_cause_ip_hw", 32'(cause_ip_hw), 0);
    reset = 1'b0;
    tick();
    status.ie = 1'b1;

    // older ov beats younger syscall
    slot_valid = 2'b11; slot_pc[1] = 32'h8000_0100; slot_pc[0] = 32'h8000_0104;
    slot_exc[1].ov = 1'b1; slot_exc[0].syscall = 1'b1;
    exp_exc(CODE_OV, 32'h8000_0100, 1'b0, 32'h0, 2'b11); exp_redir(VEC);
    finish_redirect();

    // only slot 0 valid
    slot_valid = 2'b01; slot_pc[0] = 32'h8000_0110; slot_exc[0].ri = 1'b1;
    exp_exc(CODE_RI, 32'h8000_0110, 1'b0, 32'h0, 2'b01); exp_redir(VEC);
    finish_redirect();

    // clean older slot, younger adel_mem in delay slot
    slot_valid = 2'b11; slot_pc[1] = 32'h8000_0120; slot_pc[0] = 32'h8000_0124;
    slot_dly[0] = 1'b1; slot_mem[0] = 32'h1234_5677; slot_exc[0].adel_mem = 1'b1;
    exp_exc(CODE_ADEL, 32'h8000_0124, 1'b1, 32'h1234_5677, 2'b01); exp_redir(VEC);
    finish_redirect();

    // adel_if beats ri; badvaddr is the pc
    slot_valid = 2'b10; slot_pc[1] = 32'h8000_0301; slot_mem[1] = 32'h0000_0055;
    slot_exc[1].adel_if = 1'b1; slot_exc[1].ri = 1'b1;
    exp_exc(CODE_ADEL, 32'h8000_0301, 1'b0, 32'h8000_0301, 2'b11); exp_redir(VEC);
    finish_redirect();

    // break beats ades_mem; no badvaddr
    slot_valid = 2'b10; slot_pc[1] = 32'h8000_0140; slot_mem[1] = 32'h0000_0abc;
    slot_exc[1].break_ = 1'b1; slot_exc[1].ades_mem = 1'b1;
    exp_exc(CODE_BP, 32'h8000_0140, 1'b0, 32'h0, 2'b11); exp_redir(VEC);
    finish_redirect();

    slot_valid = 2'b01; slot_pc[0] = 32'h8000_0150; slot_mem[0] = 32'h0000_1002;
    slot_exc[0].ades_mem = 1'b1;
    exp_exc(CODE_ADES, 32'h8000_0150, 1'b0, 32'h0000_1002, 2'b01); exp_redir(VEC);
    finish_redirect();

    // timer interrupt on older slot overrides its adel_if
    status.im = 8'h80; timer_int = 1'b1;
    slot_valid = 2'b11; slot_pc[1] = 32'h8000_0200; slot_pc[0] = 32'h8000_0204;
    slot_exc[1].adel_if = 1'b1; slot_exc[0].syscall = 1'b1;
    exp_exc(CODE_INT, 32'h8000_0200, 1'b0, 32'h0, 2'b11); exp_redir(VEC);
    finish_redirect();

    slot_valid = 2'b01; slot_pc[0] = 32'h8000_0210;
    exp_exc(CODE_INT, 32'h8000_0210, 1'b0, 32'h0, 2'b01); exp_redir(VEC);
    finish_redirect();

    // EXL masks interrupts but not synchronous exceptions
    status.exl = 1'b1;
    slot_valid = 2'b11; slot_pc[1] = 32'h8000_0220; slot_pc[0] = 32'h8000_0224;
    @(negedge clk);
    chk("exl_masks_irq", 32'(exc.valid), 0);
    tick(); clr_slots();
    slot_valid = 2'b10; slot_pc[1] = 32'h8000_0228; slot_exc[1].ov = 1'b1;
    exp_exc(CODE_OV, 32'h8000_0228, 1'b0, 32'h0, 2'b11); exp_redir(VEC);
    finish_redirect();
    status.exl = 1'b0; timer_int = 1'b0;

    // software interrupt IP[0]
    cause.ip_sw = 2'b01; status.im = 8'h01;
    slot_valid = 2'b10; slot_pc[1] = 32'h8000_0230; slot_dly[1] = 1'b1;
    exp_exc(CODE_INT, 32'h8000_0230, 1'b1, 32'h0, 2'b11); exp_redir(VEC);
    finish_redirect();
    cause.ip_sw = 2'b00;

    // ext_int[0] edge: visible after SYNC_LAT cycles
    status.im = 8'h04;
    exp_exc(CODE_INT, 32'h8000_0500, 1'b0, 32'h0, 2'b11); exp_redir(VEC);
    tick();
    ext_int[0] = 1'b1; slot_valid = 2'b10; slot_pc[1] = 32'h8000_0500;
    for (int j = 0; j <= SYNC_LAT; j++) begin
      @(negedge clk);
      chk($sformatf("ext_int_lat_%0d", j), 32'(cause_ip_hw[0]), (j >= SYNC_LAT) ? 32'd1 : 32'd0);
    end
    tick(); clr_slots(); ext_int = '0; status.im = 8'h00;
    repeat (SYNC_LAT + 2) tick();

    // ERET on older slot wins over younger exception
    epc = 32'h8000_0400;
    slot_valid = 2'b11; slot_pc[1] = 32'h8000_0300; slot_pc[0] = 32'h8000_0304;
    slot_eret[1] = 1'b1; slot_exc[0].ov = 1'b1;
    exp_eret(2'b01); exp_redir(32'h8000_0400);
    finish_redirect();

    // ERET on younger slot, fetch stalls, EPC captured on entry
    redirect_ready = 1'b0;
    slot_valid = 2'b11; slot_pc[1] = 32'h8000_0310; slot_pc[0] = 32'h8000_0314; slot_eret[0] = 1'b1;
    exp_eret(2'b00); exp_redir(32'h8000_0400);
    tick(); clr_slots();
    @(negedge clk);
    chk("eret_redir_pc_first", redirect_pc, 32'h8000_0400);
    tick(); epc = 32'hDEAD_0000;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("eret_redir_pc_held", redirect_pc, 32'h8000_0400);
      chk("eret_redir_valid_held", 32'(redirect_valid), 1);
      tick();
    end
    redirect_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("eret_back_idle", 32'(redirect_valid), 0);
    tick();

    // ERET and exception in same slot: exception wins
    slot_valid = 2'b10; slot_pc[1] = 32'h8000_0600; slot_eret[1] = 1'b1; slot_exc[1].syscall = 1'b1;
    exp_exc(CODE_SYS, 32'h8000_0600, 1'b0, 32'h0, 2'b11); exp_redir(VEC);
    finish_redirect();

    // ready low for 3 cycles; slot inputs during redirect ignored
    redirect_ready = 1'b0;
    slot_valid = 2'b10; slot_pc[1] = 32'h8000_0700; slot_exc[1].syscall = 1'b1;
    exp_exc(CODE_SYS, 32'h8000_0700, 1'b0, 32'h0, 2'b11); exp_redir(VEC);
    tick(); clr_slots();
    slot_valid = 2'b11; slot_exc[1].ri = 1'b1; slot_eret[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_redirect_valid", 32'(redirect_valid), 1);
      chk("stall_redirect_pc", redirect_pc, VEC);
      chk("stall_commit", 32'(stall_commit), 1);
      tick();
    end
    redirect_ready = 1'b1; clr_slots();
    tick();
    @(negedge clk);
    chk("stall_back_idle", 32'(redirect_valid), 0);
    chk("stall_released", 32'(stall_commit), 0);
    tick();

    // reset during EXC_REDIR drops the redirect
    redirect_ready = 1'b0;
    slot_valid = 2'b10; slot_pc[1] = 32'h8000_0800; slot_exc[1].syscall = 1'b1;
    exp_exc(CODE_SYS, 32'h8000_0800, 1'b0, 32'h0, 2'b11);
    tick(); clr_slots();
    @(negedge clk);
    chk("redir_before_reset", 32'(redirect_valid), 1);
    #2 reset = 1'b1;
    #1;
    chk("reset_drops_redirect", 32'(redirect_valid), 0);
    chk("reset_drops_stall", 32'(stall_commit), 0);
    tick();
    reset = 1'b0; redirect_ready = 1'b1;
    @(negedge clk);
    chk("post_reset_redirect_valid", 32'(redirect_valid), 0);
    chk("post_reset_redirect_pc", redirect_pc, 0);
    chk("post_reset_kill", 32'(commit_kill), 0);
    chk("post_reset_exc_valid", 32'(exc.valid), 0);
    tick();

    // unit still works after reset
    slot_valid = 2'b10; slot_pc[1] = 32'h8000_0900; slot_exc[1].break_ = 1'b1;
    exp_exc(CODE_BP, 32'h8000_0900, 1'b0, 32'h0, 2'b11); exp_redir(VEC);
    finish_redirect();

    repeat (3) tick();
    chk("scoreboard_drained", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
